// File: rtl/pipe_pkg.sv
// Shared types for the MEM stage: FSM state, alignment mask and the MEM/WB field bundle.
package pipe_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    typedef struct packed {
        logic        regWrite;
        logic        memtoReg;
        logic [4:0]  writeReg;
        logic [31:0] readData;
        logic [31:0] aluOut;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a stalled cycle inserts a bubble and keeps the data fields.
import pipe_pkg::*;

module mem_wb_reg (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bubble,
    input  logic    loadAck,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q.regWrite <= 1'b0;
            q.memtoReg <= 1'b0;
        end else begin
            q.regWrite <= d.regWrite;
            q.memtoReg <= d.memtoReg;
            q.writeReg <= d.writeReg;
            q.aluOut   <= d.aluOut;
            // Load data only moves on a completed load; otherwise the last value is held.
            if (loadAck) begin
                q.readData <= d.readData;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on the data bus, stalls the pipeline while the
// memory is slow, aborts on timeout and drives the MEM/WB register.
import pipe_pkg::*;

module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ResultW,
    output logic        misalign_err,
    output logic        bus_err
);

    // Bus handshake: dmem_req is raised with stable dmem_we/addr/wdata and held until
    // the cycle dmem_ack = 1, which completes the access in that same cycle; an ack
    // seen while no request is outstanding is ignored.

    mem_state_t     state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic           memop, isLoad, dualOp, misaligned;
    logic           reqInt, stallInt, abort, misal, loadAck;
    mem_wb_t        wbD, wbQ;

    assign memop      = MemtoRegM | MemWriteM;
    assign dualOp     = MemtoRegM & MemWriteM;
    assign isLoad     = MemtoRegM & ~MemWriteM;
    assign misaligned = memop && ((ALUOutM & ALIGN_MASK) != 32'd0);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        reqInt    = 1'b0;
        stallInt  = 1'b0;
        abort     = 1'b0;
        misal     = 1'b0;
        loadAck   = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    if (misaligned) begin
                        misal = 1'b1;
                    end else begin
                        reqInt = 1'b1;
                        if (dmem_ack) begin
                            loadAck = isLoad;
                        end else begin
                            stallInt  = 1'b1;
                            stateNext = BUSY;
                            cntNext   = CNT_W'(1);
                        end
                    end
                end
            end
            BUSY: begin
                // The request stays up in the final waiting cycle, so a last-moment ack still completes.
                reqInt = 1'b1;
                if (dmem_ack) begin
                    loadAck   = isLoad;
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt >= CNT_W'(TIMEOUT)) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    stallInt = 1'b1;
                    cntNext  = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
        if (!rst_n) begin
            reqInt   = 1'b0;
            stallInt = 1'b0;
            loadAck  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            misalign_err <= misal;
            bus_err      <= abort;
        end
    end

    assign dmem_req   = reqInt;
    assign dmem_we    = reqInt & MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = stallInt;

    // A store-and-load encoding is treated as a store, so it never writes a register.
    always_comb begin
        wbD          = '0;
        wbD.regWrite = RegWriteM & ~dualOp & ~misal & ~abort;
        wbD.memtoReg = isLoad;
        wbD.writeReg = WriteRegM;
        wbD.readData = dmem_rdata;
        wbD.aluOut   = ALUOutM;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (stallInt),
        .loadAck (loadAck),
        .d       (wbD),
        .q       (wbQ)
    );

    assign RegWriteW = wbQ.regWrite;
    assign MemtoRegW = wbQ.memtoReg;
    assign WriteRegW = wbQ.writeReg;
    assign ReadDataW = wbQ.readData;
    assign ALUOutW   = wbQ.aluOut;
    assign ResultW   = wbQ.memtoReg ? wbQ.readData : wbQ.aluOut;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random transactions against a
// transaction-level model of stall count, abort and MEM/WB contents.
module tb_mem_stage;

    localparam int TIMEOUT = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        StallM, RegWriteW, MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW, ALUOutW, ResultW;
    logic        misalign_err, bus_err;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .WriteRegW(WriteRegW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .ResultW(ResultW), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: expected ResultW of each retired instruction
    logic [31:0] exp_q[$];

    // model of the MEM/WB contents
    logic        mRegWrite, mMemtoReg;
    logic [4:0]  mWriteReg;
    logic [31:0] mAlu, mRd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag);
        chk({tag, ".RegWriteW"}, RegWriteW, mRegWrite);
        chk({tag, ".MemtoRegW"}, MemtoRegW, mMemtoReg);
        chk({tag, ".WriteRegW"}, WriteRegW, mWriteReg);
        chk({tag, ".ALUOutW"},   ALUOutW,   mAlu);
        chk({tag, ".ReadDataW"}, ReadDataW, mRd);
        chk({tag, ".ResultW"},   ResultW,   mMemtoReg ? mRd : mAlu);
    endtask

    // driver: one instruction in M. lat = cycles before ack (negative = never).
    task automatic run_op(input logic rw, input logic mtr, input logic mw, input logic [4:0] wr,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdv,
                          input int lat);
        logic memop, mis, aligned, abort;
        int   nStall;
        memop   = mtr | mw;
        mis     = memop && (alu[1:0] != 2'b00);
        aligned = memop && !mis;
        abort   = aligned && (lat < 0 || lat > TIMEOUT);
        nStall  = !aligned ? 0 : (abort ? TIMEOUT : lat);
        RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
        WriteRegM = wr; ALUOutM = alu; WriteDataM = wd;
        for (int c = 0; c <= nStall; c++) begin
            if (aligned) dmem_ack = (c == lat);
            else         dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = (aligned && c == lat) ? rdv : $urandom();
            #2;
            chk("dmem_req", dmem_req, aligned);
            if (aligned) begin
                chk("dmem_we", dmem_we, mw);
                chk("dmem_addr", dmem_addr, alu);
                chk("dmem_wdata", dmem_wdata, wd);
            end
            chk("StallM", StallM, c < nStall);
            @(posedge clk); #1;
            if (c < nStall) begin
                mRegWrite = 1'b0;
                mMemtoReg = 1'b0;
                chk_w("bubble");
                chk("misalign_err_idle", misalign_err, 1'b0);
                chk("bus_err_idle", bus_err, 1'b0);
                @(negedge clk);
            end
        end
        mRegWrite = rw & !(mtr & mw) & !mis & !abort;
        mMemtoReg = mtr & !mw;
        mWriteReg = wr;
        mAlu      = alu;
        if (aligned && !abort && mtr && !mw) mRd = rdv;
        exp_q.push_back(mMemtoReg ? mRd : mAlu);
        chk_w("retire");
        chk("misalign_err", misalign_err, mis);
        chk("bus_err", bus_err, abort);
        chk("ResultW_sb", ResultW, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic drive_idle();
        RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        WriteRegM = '0; ALUOutM = '0; WriteDataM = '0;
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        // reset with an aligned load on the inputs: bus and stall must stay low
        rst_n = 1'b0;
        drive_idle();
        MemtoRegM = 1'b1; ALUOutM = 32'h40;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_StallM", StallM, 1'b0);
        mRegWrite = 0; mMemtoReg = 0; mWriteReg = 0; mAlu = 0; mRd = 0;
        chk_w("reset");
        chk("rst_misalign_err", misalign_err, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // directed cases
        run_op(1'b1, 1'b0, 1'b0, 5'd8,  32'h0000_0010, 32'h0, 32'h0, -1);
        run_op(1'b1, 1'b1, 1'b0, 5'd9,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        run_op(1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0200, 32'h1234, 32'h0, 2);
        run_op(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 0);
        run_op(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0300, 32'h0, 32'h0, -1);
        run_op(1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0ABC, 32'h0, 32'h0, -1);
        run_op(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0);
        run_op(1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_0404, 32'h0, 32'h0BAD_CAFE, TIMEOUT);
        run_op(1'b1, 1'b1, 1'b1, 5'd15, 32'h0000_0408, 32'h77, 32'h0, 1);

        // random transactions
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            a = $urandom() & 32'hFFFF_FFFC;
            if (kind == 4) a = a | 32'($urandom_range(1, 3));
            run_op(1'($urandom_range(0, 1)),
                   (kind == 1 || kind == 3 || kind == 4),
                   (kind == 2 || kind == 3),
                   5'($urandom_range(0, 31)), a, $urandom(), $urandom(),
                   $urandom_range(0, TIMEOUT + 2));
        end

        // reset in the middle of a wait, then a stale ack
        RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
        WriteRegM = 5'd20; ALUOutM = 32'h0000_0800; WriteDataM = '0;
        dmem_ack = 1'b0;
        #2;
        chk("busy_req", dmem_req, 1'b1);
        chk("busy_StallM", StallM, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        #2;
        chk("busy2_StallM", StallM, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 1'b0);
        chk("midrst_StallM", StallM, 1'b0);
        @(posedge clk); #1;
        mRegWrite = 0; mMemtoReg = 0; mWriteReg = 0; mAlu = 0; mRd = 0;
        chk_w("midrst");
        chk("midrst_bus_err", bus_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBADB_AD00;
        #2;
        chk("stale_req", dmem_req, 1'b0);
        @(posedge clk); #1;
        chk_w("stale_ack");
        chk("stale_bus_err", bus_err, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
